store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of store entries (power of two, >= 2).
REQ-002 SHALL have parameter ROB_IDX_W, default 4, meaning ROB index width.
REQ-003 SHALL have port in_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port in_rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_st_valid  input  1  executed store to allocate.
REQ-006 SHALL have ports in_st_addr and in_st_data  input  64 each  store address and store value.
REQ-007 SHALL have port in_st_rob_index  input  ROB_IDX_W  ROB slot of the store.
REQ-008 SHALL have port out_st_ready  output  1  high when an entry is free.
REQ-009 SHALL have port in_ld_addr  input  64  load address for forwarding lookup.
REQ-010 SHALL have ports out_ld_hit (output, 1) and out_ld_data (output, 64)  forwarding result.
REQ-011 SHALL have port in_commit  input  1  ROB retired the oldest uncommitted store.
REQ-012 SHALL have port in_flush  input  1  mispredict, discard speculative stores.
REQ-013 SHALL have ports out_dmem_w_enable (output, 1), out_dmem_addr (output, 64) and out_dmem_wval (output, 64)  dmem write port.
REQ-014 SHALL have ports out_count (output, $clog2(DEPTH)+1) and out_empty (output, 1)  occupancy.

Function
REQ-015 SHALL hold a circular FIFO with pointers head (oldest entry), cmt (oldest uncommitted entry) and tail (next free entry); each entry holds valid, committed, addr, data and rob_index.
REQ-016 SHALL allocate at tail on a cycle with in_st_valid & out_st_ready; the entry becomes valid and uncommitted; tail advances mod DEPTH.
REQ-017 SHALL drive out_st_ready = (out_count < DEPTH); in_st_valid while out_st_ready is low SHALL be ignored with no state change.
REQ-018 SHALL set committed on the entry at cmt when in_commit is high and that entry is valid and uncommitted, then advance cmt; in_commit with no uncommitted entry SHALL be ignored.
REQ-019 SHALL, on in_flush, invalidate every uncommitted entry and set tail = cmt in that same edge; committed entries SHALL be kept and still drained.
REQ-020 SHALL give in_flush priority over in_st_valid in the same cycle: the store is not allocated.
REQ-021 SHALL apply in_commit before in_flush in the same cycle: the entry at cmt commits and survives the flush.
REQ-022 SHALL use a two-state drain FSM: IDLE -> WRITE when the head entry is valid and committed; WRITE -> IDLE unconditionally after one cycle.
REQ-023 SHALL, on the IDLE->WRITE edge, register the head addr and data onto out_dmem_addr and out_dmem_wval, pop head and decrement out_count.
REQ-024 SHALL hold out_dmem_w_enable high for exactly the one WRITE cycle, so at most one dmem write occurs every two cycles.
REQ-025 SHALL update out_count with the net effect of allocate (+1), pop (-1) and flush (minus the uncommitted count) on one edge; allocate and pop in the same cycle leave it unchanged.
REQ-026 SHALL compute the load lookup combinationally: out_ld_hit = some valid entry has addr == in_ld_addr (exact 64-bit match); out_ld_data = data of the youngest such entry (nearest to tail).
REQ-027 SHALL include the entry in the WRITE register in the load lookup during WRITE, at lowest priority, so a load never sees a stale value.
REQ-028 SHALL drive out_ld_data = 0 when out_ld_hit = 0.
REQ-029 SHALL drive out_empty = (out_count == 0) and not in WRITE.
REQ-030 SHALL handle wrap-around of head, cmt and tail mod DEPTH; full and empty are distinguished by out_count, not by pointer equality.

Reset
REQ-031 SHALL, on any rising edge with in_rst = 0, set head = cmt = tail = 0, all entries invalid and uncommitted, FSM = IDLE, out_count = 0, out_dmem_w_enable = 0, out_dmem_addr = 0 and out_dmem_wval = 0.
REQ-032 SHALL make reset override all other inputs; a write in progress SHALL be abandoned with no further write enable.
REQ-033 SHALL, after reset, show out_st_ready = 1, out_empty = 1 and out_ld_hit = 0.

Verification
REQ-034 SHALL be covered by test 1, basic drain: store (0x10, 5), commit the next cycle -> out_dmem_w_enable pulses one cycle with addr 0x10 and wval 5, then out_empty = 1.
REQ-035 SHALL be covered by test 2, full: 4 stores with no commit -> out_st_ready = 0 and out_count = 4; a 5th store is dropped; one commit plus drain -> out_st_ready = 1.
REQ-036 SHALL be covered by test 3, forwarding: stores (0x20, 1) then (0x20, 2) and lookup 0x20 -> hit with data 2; lookup 0x28 -> hit = 0 with data 0.
REQ-037 SHALL be covered by test 4, flush: 3 stores, commit 1, flush -> out_count = 1 with only the committed store drained; a store presented with the flush is not allocated.
REQ-038 SHALL be covered by test 5, wrap: 10 store/commit pairs through DEPTH = 4 -> 10 writes in program order, with correct addr and data.
REQ-039 SHALL be covered by test 6, reset mid-WRITE: in_rst low during WRITE -> next cycle out_dmem_w_enable = 0, out_count = 0 and out_empty = 1.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: speculative store FIFO with commit, flush, load forwarding and a one-write-per-two-cycle dmem drain
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int ROB_IDX_W = 4
) (
  input  logic                   in_clk,
  input  logic                   in_rst,
  input  logic                   in_st_valid,
  input  logic [63:0]            in_st_addr,
  input  logic [63:0]            in_st_data,
  input  logic [ROB_IDX_W-1:0]   in_st_rob_index,
  output logic                   out_st_ready,
  input  logic [63:0]            in_ld_addr,
  output logic                   out_ld_hit,
  output logic [63:0]            out_ld_data,
  input  logic                   in_commit,
  input  logic                   in_flush,
  output logic                   out_dmem_w_enable,
  output logic [63:0]            out_dmem_addr,
  output logic [63:0]            out_dmem_wval,
  output logic [$clog2(DEPTH):0] out_count,
  output logic                   out_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state, state_nx;
  logic [DEPTH-1:0] valid, committed;
  logic [63:0] addr [DEPTH];
  logic [63:0] data [DEPTH];
  logic [ROB_IDX_W-1:0] rob [DEPTH];
  logic [PW-1:0] head, cmt, tail, cmt_nx;
  logic alloc, commit, pop;
  logic [CW-1:0] ucnt, flushed;
  assign out_st_ready = out_count < CW'(DEPTH);
  assign out_empty = out_count == '0 && state != WRITE;
  assign out_dmem_w_enable = state == WRITE;
  // Per-cycle control: flush blocks allocation, commit is applied before flush
  always_comb begin
    alloc = in_st_valid & out_st_ready & ~in_flush;
    commit = in_commit & valid[cmt] & ~committed[cmt];
    cmt_nx = commit ? cmt + PW'(1) : cmt;
    ucnt = '0;
    for (int i = 0; i < DEPTH; i++) ucnt = ucnt + CW'(valid[i] & ~committed[i]);
    flushed = in_flush ? ucnt - CW'(commit) : '0;
  end
  // Drain FSM next state: a committed head starts a single-cycle write
  always_comb begin
    pop = state == IDLE && valid[head] && committed[head];
    state_nx = pop ? WRITE : IDLE;
  end
  // Drain FSM state register; reset abandons any write in progress
  always_ff @(posedge in_clk) state <= !in_rst ? IDLE : state_nx;
  // Entry payload storage; validity is tracked separately so no reset is needed
  always_ff @(posedge in_clk) begin
    if (alloc) begin
      addr[tail] <= in_st_addr;
      data[tail] <= in_st_data;
      rob[tail] <= in_st_rob_index;
    end
  end
  // Entry flags, pointers, occupancy and the dmem write register
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      valid <= '0;
      committed <= '0;
      head <= '0;
      cmt <= '0;
      tail <= '0;
      out_count <= '0;
      out_dmem_addr <= '0;
      out_dmem_wval <= '0;
    end else begin
      if (alloc) begin
        valid[tail] <= 1'b1;
        committed[tail] <= 1'b0;
        tail <= tail + PW'(1);
      end
      if (commit) committed[cmt] <= 1'b1;
      cmt <= cmt_nx;
      if (in_flush) begin
        for (int i = 0; i < DEPTH; i++)
          if (valid[i] && !committed[i] && !(commit && PW'(i) == cmt)) valid[i] <= 1'b0;
        tail <= cmt_nx;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        committed[head] <= 1'b0;
        head <= head + PW'(1);
        out_dmem_addr <= addr[head];
        out_dmem_wval <= data[head];
      end
      out_count <= out_count + CW'(alloc) - CW'(pop) - flushed;
    end
  end
  // Load forwarding: write register lowest priority, then entries oldest to youngest so the youngest wins
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    out_ld_hit = state == WRITE && out_dmem_addr == in_ld_addr;
    out_ld_data = out_ld_hit ? out_dmem_wval : '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && addr[idx] == in_ld_addr) begin
        out_ld_hit = 1'b1;
        out_ld_data = data[idx];
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer
module tb_store_buffer;
  logic in_clk = 1'b0, in_rst = 1'b0, in_st_valid = 1'b0, in_commit = 1'b0, in_flush = 1'b0;
  logic [63:0] in_st_addr = '0, in_st_data = '0, in_ld_addr = '0;
  logic [3:0] in_st_rob_index = '0;
  logic out_st_ready, out_ld_hit, out_dmem_w_enable, out_empty;
  logic [63:0] out_ld_data, out_dmem_addr, out_dmem_wval;
  logic [2:0] out_count;
  int checks = 0, errors = 0;
  always #5 in_clk = ~in_clk;
  store_buffer #(.DEPTH(4), .ROB_IDX_W(4)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_st_valid(in_st_valid), .in_st_addr(in_st_addr),
    .in_st_data(in_st_data), .in_st_rob_index(in_st_rob_index), .out_st_ready(out_st_ready),
    .in_ld_addr(in_ld_addr), .out_ld_hit(out_ld_hit), .out_ld_data(out_ld_data),
    .in_commit(in_commit), .in_flush(in_flush), .out_dmem_w_enable(out_dmem_w_enable),
    .out_dmem_addr(out_dmem_addr), .out_dmem_wval(out_dmem_wval), .out_count(out_count),
    .out_empty(out_empty)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge in_clk);
    #1;
  endtask
  task automatic store(input logic [63:0] a, input logic [63:0] d);
    in_st_valid = 1'b1;
    in_st_addr = a;
    in_st_data = d;
    in_st_rob_index = in_st_rob_index + 4'd1;
    tick;
    in_st_valid = 1'b0;
  endtask
  task automatic commit1;
    in_commit = 1'b1;
    tick;
    in_commit = 1'b0;
  endtask
  task automatic flush1;
    in_flush = 1'b1;
    tick;
    in_flush = 1'b0;
  endtask
  task automatic look(input string tag, input logic [63:0] a, input logic hit, input logic [63:0] d);
    in_ld_addr = a;
    #1;
    chk({tag, "_hit"}, 64'(out_ld_hit), 64'(hit));
    chk({tag, "_data"}, out_ld_data, d);
  endtask
  initial begin
    tick;
    tick;
    in_rst = 1'b1;
    chk("rst_ready", 64'(out_st_ready), 64'd1);
    chk("rst_empty", 64'(out_empty), 64'd1);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_wen", 64'(out_dmem_w_enable), 64'd0);
    chk("rst_daddr", out_dmem_addr, 64'd0);
    look("rst_ld", 64'h0, 1'b0, 64'd0);
    // basic drain
    store(64'h10, 64'd5);
    chk("t1_count", 64'(out_count), 64'd1);
    chk("t1_empty", 64'(out_empty), 64'd0);
    look("t1_fwd", 64'h10, 1'b1, 64'd5);
    commit1;
    chk("t1_wen_pre", 64'(out_dmem_w_enable), 64'd0);
    tick;
    chk("t1_wen", 64'(out_dmem_w_enable), 64'd1);
    chk("t1_addr", out_dmem_addr, 64'h10);
    chk("t1_wval", out_dmem_wval, 64'd5);
    chk("t1_count_w", 64'(out_count), 64'd0);
    chk("t1_empty_w", 64'(out_empty), 64'd0);
    look("t1_fwd_w", 64'h10, 1'b1, 64'd5);
    tick;
    chk("t1_wen_off", 64'(out_dmem_w_enable), 64'd0);
    chk("t1_empty_end", 64'(out_empty), 64'd1);
    look("t1_fwd_end", 64'h10, 1'b0, 64'd0);
    // full
    for (int i = 0; i < 4; i++) store(64'h100 + 64'(i), 64'hA0 + 64'(i));
    chk("t2_count", 64'(out_count), 64'd4);
    chk("t2_ready", 64'(out_st_ready), 64'd0);
    store(64'h200, 64'hBB);
    chk("t2_drop_count", 64'(out_count), 64'd4);
    look("t2_drop_ld", 64'h200, 1'b0, 64'd0);
    look("t2_ld_wrap", 64'h103, 1'b1, 64'hA3);
    commit1;
    chk("t2_ready_c", 64'(out_st_ready), 64'd0);
    tick;
    chk("t2_wen", 64'(out_dmem_w_enable), 64'd1);
    chk("t2_addr", out_dmem_addr, 64'h100);
    chk("t2_wval", out_dmem_wval, 64'hA0);
    chk("t2_ready_d", 64'(out_st_ready), 64'd1);
    chk("t2_count_d", 64'(out_count), 64'd3);
    tick;
    flush1;
    chk("t2_flush_count", 64'(out_count), 64'd0);
    chk("t2_flush_empty", 64'(out_empty), 64'd1);
    // forwarding
    store(64'h20, 64'd1);
    store(64'h20, 64'd2);
    look("t3_young", 64'h20, 1'b1, 64'd2);
    look("t3_miss", 64'h28, 1'b0, 64'd0);
    flush1;
    chk("t3_flush_count", 64'(out_count), 64'd0);
    // flush with same-cycle commit and store
    store(64'h40, 64'h11);
    store(64'h48, 64'h22);
    store(64'h50, 64'h33);
    chk("t4_count3", 64'(out_count), 64'd3);
    in_commit = 1'b1;
    in_flush = 1'b1;
    in_st_valid = 1'b1;
    in_st_addr = 64'h58;
    in_st_data = 64'h44;
    tick;
    in_commit = 1'b0;
    in_flush = 1'b0;
    in_st_valid = 1'b0;
    chk("t4_count1", 64'(out_count), 64'd1);
    look("t4_st_drop", 64'h58, 1'b0, 64'd0);
    look("t4_flushed", 64'h48, 1'b0, 64'd0);
    look("t4_kept", 64'h40, 1'b1, 64'h11);
    tick;
    chk("t4_wen", 64'(out_dmem_w_enable), 64'd1);
    chk("t4_addr", out_dmem_addr, 64'h40);
    chk("t4_wval", out_dmem_wval, 64'h11);
    tick;
    chk("t4_wen_off", 64'(out_dmem_w_enable), 64'd0);
    chk("t4_empty", 64'(out_empty), 64'd1);
    tick;
    chk("t4_no_more", 64'(out_dmem_w_enable), 64'd0);
    // commit with nothing uncommitted is ignored
    commit1;
    store(64'h60, 64'd7);
    tick;
    chk("tc_wen0", 64'(out_dmem_w_enable), 64'd0);
    tick;
    chk("tc_wen1", 64'(out_dmem_w_enable), 64'd0);
    chk("tc_count", 64'(out_count), 64'd1);
    flush1;
    chk("tc_flush", 64'(out_count), 64'd0);
    // wrap-around
    for (int i = 0; i < 10; i++) begin
      store(64'h1000 + 64'(8 * i), 64'hD000 + 64'(i));
      commit1;
      tick;
      chk($sformatf("t5_wen_%0d", i), 64'(out_dmem_w_enable), 64'd1);
      chk($sformatf("t5_addr_%0d", i), out_dmem_addr, 64'h1000 + 64'(8 * i));
      chk($sformatf("t5_wval_%0d", i), out_dmem_wval, 64'hD000 + 64'(i));
      tick;
      chk($sformatf("t5_off_%0d", i), 64'(out_dmem_w_enable), 64'd0);
    end
    chk("t5_empty", 64'(out_empty), 64'd1);
    // reset mid-write
    store(64'h70, 64'd9);
    store(64'h78, 64'd10);
    commit1;
    tick;
    chk("t6_wen", 64'(out_dmem_w_enable), 64'd1);
    chk("t6_count", 64'(out_count), 64'd1);
    in_rst = 1'b0;
    tick;
    chk("t6_rst_wen", 64'(out_dmem_w_enable), 64'd0);
    chk("t6_rst_count", 64'(out_count), 64'd0);
    chk("t6_rst_empty", 64'(out_empty), 64'd1);
    chk("t6_rst_daddr", out_dmem_addr, 64'd0);
    in_rst = 1'b1;
    tick;
    chk("t6_after_wen", 64'(out_dmem_w_enable), 64'd0);
    chk("t6_after_ready", 64'(out_st_ready), 64'd1);
    look("t6_after_ld", 64'h78, 1'b0, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
